// File: rtl/nv_ram_rwsthp_gen.sv
// Parametrised 1R1W RAM: registered read address stage, output register, late bypass mux.
// Define NV_RAM_RWSTHP_WRFWD_EN for write-first same-address forwarding (default: read-first).
module nv_ram_rwsthp_gen #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 60,
    parameter int AW    = 6
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    input  logic             byp_sel,
    input  logic [WIDTH-1:0] dbyp,
    output logic             oob_err,
    input  logic [31:0]      pwrbus_ram_pd
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] mem_q;
    logic             oob_q;
    logic             rd_seen;
    logic             wr_ok;
    logic             rd_ok;
    logic             unused_pwrbus;

    assign unused_pwrbus = ^pwrbus_ram_pd;

    always_comb begin
        wr_ok = 1'b0;
        rd_ok = 1'b0;
        if ({1'b0, wa} < DEPTH_W) wr_ok = 1'b1;
        if ({1'b0, ra} < DEPTH_W) rd_ok = 1'b1;
    end

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge nvdla_core_clk) begin
        if (we && wr_ok) begin
            mem[wa] <= di;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            mem_q    <= '0;
            oob_q    <= 1'b0;
            rd_seen  <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
            oob_err  <= 1'b0;
        end else begin
            if (re) begin
                rd_seen <= 1'b1;
                oob_q   <= !rd_ok;
                if (!rd_ok) begin
                    mem_q <= '0;
`ifdef NV_RAM_RWSTHP_WRFWD_EN
                end else if (we && wr_ok && (wa == ra)) begin
                    mem_q <= di;
`endif
                end else begin
                    mem_q <= mem[ra];
                end
            end

            if (ore) begin
                dout_vld <= byp_sel | rd_seen;
                if (byp_sel) begin
                    dout <= dbyp;
                end else if (oob_q) begin
                    dout <= '0;
                end else begin
                    dout <= mem_q;
                end
            end

            if ((we && !wr_ok) || (re && !rd_ok)) begin
                oob_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nv_ram_rwsthp_gen.sv
// Directed bench for nv_ram_rwsthp_gen: spec-level model on the default geometry,
// plus literal checks on 1x2 and 256x4096 instances.
module tb_nv_ram_rwsthp_gen;

`ifdef NV_RAM_RWSTHP_WRFWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // default geometry
    logic [5:0]  ra = '0, wa = '0;
    logic        re = 1'b0, ore = 1'b0, we = 1'b0, byp_sel = 1'b0;
    logic [41:0] di = '0, dbyp = '0, dout;
    logic        dout_vld, oob_err;
    logic [31:0] pwr = 32'hA5A5_0F0F;

    // WIDTH=1 DEPTH=2 AW=1
    logic        s_ra = 1'b0, s_wa = 1'b0, s_re = 1'b0, s_ore = 1'b0, s_we = 1'b0;
    logic        s_di = 1'b0, s_dout, s_vld, s_err;

    // WIDTH=256 DEPTH=4096 AW=12
    logic [11:0]  b_ra = '0, b_wa = '0;
    logic         b_re = 1'b0, b_ore = 1'b0, b_we = 1'b0;
    logic [255:0] b_di = '0, b_dout;
    logic         b_vld, b_err;

    nv_ram_rwsthp_gen #(.WIDTH(42), .DEPTH(60), .AW(6)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .ra(ra), .re(re), .ore(ore), .dout(dout), .dout_vld(dout_vld),
        .wa(wa), .we(we), .di(di), .byp_sel(byp_sel), .dbyp(dbyp),
        .oob_err(oob_err), .pwrbus_ram_pd(pwr)
    );

    nv_ram_rwsthp_gen #(.WIDTH(1), .DEPTH(2), .AW(1)) dut_s (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .ra(s_ra), .re(s_re), .ore(s_ore), .dout(s_dout), .dout_vld(s_vld),
        .wa(s_wa), .we(s_we), .di(s_di), .byp_sel(1'b0), .dbyp(1'b0),
        .oob_err(s_err), .pwrbus_ram_pd(pwr)
    );

    nv_ram_rwsthp_gen #(.WIDTH(256), .DEPTH(4096), .AW(12)) dut_b (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .ra(b_ra), .re(b_re), .ore(b_ore), .dout(b_dout), .dout_vld(b_vld),
        .wa(b_wa), .we(b_we), .di(b_di), .byp_sel(1'b0), .dbyp(256'd0),
        .oob_err(b_err), .pwrbus_ram_pd(pwr)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [41:0] pat(input int i);
        return 42'(i) * 42'h0_0123_4567 + 42'h5;
    endfunction

    // Behavioural view: array contents, latest issued read result, output register.
    logic [41:0] m_mem [60];
    logic [41:0] m_rd = '0, m_dout = '0;
    logic        m_rd_seen = 1'b0, m_vld = 1'b0, m_err = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_rd <= '0; m_rd_seen <= 1'b0;
            m_dout <= '0; m_vld <= 1'b0; m_err <= 1'b0;
        end else begin
            if (re) begin
                m_rd_seen <= 1'b1;
                if (int'(ra) >= 60)                m_rd <= '0;
                else if (FWD && we && wa == ra)    m_rd <= di;
                else                               m_rd <= m_mem[ra];
            end
            if (ore) begin
                m_dout <= byp_sel ? dbyp : m_rd;
                m_vld  <= byp_sel | m_rd_seen;
            end
            if (we && int'(wa) < 60) m_mem[wa] <= di;
            if ((we && int'(wa) >= 60) || (re && int'(ra) >= 60)) m_err <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("model_dout", 256'(dout), 256'(m_dout));
            chk("model_vld", 256'(dout_vld), 256'(m_vld));
            chk("model_oob_err", 256'(oob_err), 256'(m_err));
        end
    end

    initial begin
        logic [255:0] b_old, b_new;
        b_old = {8{32'hDEAD_0001}};
        b_new = {8{32'h0BAD_F00D}};

        repeat (3) tick();
        chk("reset_dout", 256'(dout), 256'd0);
        chk("reset_vld", 256'(dout_vld), 256'd0);
        chk("reset_err", 256'(oob_err), 256'd0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 60; i++) begin
            we = 1'b1; wa = 6'(i); di = pat(i);
            tick();
        end
        wa = 6'd5; di = 42'h2A_0000_1234;
        tick();
        we = 1'b0;

        // basic read
        re = 1'b1; ra = 6'd5;
        tick();
        chk("basic_pre_dout", 256'(dout), 256'd0);
        chk("basic_pre_vld", 256'(dout_vld), 256'd0);
        re = 1'b0; ore = 1'b1;
        tick();
        chk("basic_dout", 256'(dout), 256'(42'h2A_0000_1234));
        chk("basic_vld", 256'(dout_vld), 256'd1);
        ore = 1'b0;

        // same-cycle collision
        we = 1'b1; wa = 6'd7; di = 42'h111;
        tick();
        di = 42'h222; re = 1'b1; ra = 6'd7;
        tick();
        we = 1'b0; re = 1'b0; ore = 1'b1;
        tick();
        chk("collide_dout", 256'(dout), FWD ? 256'h222 : 256'h111);
        ore = 1'b0; re = 1'b1;
        tick();
        re = 1'b0; ore = 1'b1;
        tick();
        chk("collide_after", 256'(dout), 256'h222);

        // bypass then hold
        byp_sel = 1'b1; dbyp = 42'h3FF;
        tick();
        chk("byp_dout", 256'(dout), 256'h3FF);
        chk("byp_vld", 256'(dout_vld), 256'd1);
        ore = 1'b0; byp_sel = 1'b0; dbyp = '0;
        for (int i = 0; i < 5; i++) begin
            re = (i % 2 == 0); ra = 6'(i + 10);
            tick();
            chk("hold_dout", 256'(dout), 256'h3FF);
        end
        re = 1'b0;

        // out-of-range write then read
        we = 1'b1; wa = 6'd62; di = 42'h3_FFFF_FFFF;
        tick();
        chk("oob_wr_err", 256'(oob_err), 256'd1);
        we = 1'b0; re = 1'b1; ra = 6'd61;
        tick();
        re = 1'b0; ore = 1'b1;
        tick();
        chk("oob_rd_dout", 256'(dout), 256'd0);
        chk("oob_rd_vld", 256'(dout_vld), 256'd1);
        // back-to-back sweep of the whole array; model compares every cycle
        for (int i = 0; i < 60; i++) begin
            re = 1'b1; ra = 6'(i);
            tick();
        end
        re = 1'b0;
        tick();
        chk("sweep_last", 256'(dout), 256'(pat(59)));
        ore = 1'b0;
        repeat (100) tick();
        chk("oob_sticky", 256'(oob_err), 256'd1);

        // reset mid-read
        re = 1'b1; ra = 6'd3;
        tick();
        rstn = 1'b0; re = 1'b0; ore = 1'b1;
        #1;
        chk("rst_async_dout", 256'(dout), 256'd0);
        chk("rst_async_vld", 256'(dout_vld), 256'd0);
        chk("rst_async_err", 256'(oob_err), 256'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("rst_stale_dout", 256'(dout), 256'd0);
        chk("rst_stale_vld", 256'(dout_vld), 256'd0);
        ore = 1'b0; re = 1'b1; ra = 6'd3;
        tick();
        re = 1'b0; ore = 1'b1;
        tick();
        chk("rst_reread", 256'(dout), 256'(pat(3)));
        ore = 1'b0;

        // parametrised instances at their highest address
        s_we = 1'b1; s_wa = 1'b1; s_di = 1'b1;
        b_we = 1'b1; b_wa = 12'd4095; b_di = b_old;
        tick();
        s_we = 1'b0; s_re = 1'b1; s_ra = 1'b1;
        b_we = 1'b0; b_re = 1'b1; b_ra = 12'd4095;
        tick();
        s_re = 1'b0; s_ore = 1'b1; b_re = 1'b0; b_ore = 1'b1;
        tick();
        chk("s_basic", 256'(s_dout), 256'd1);
        chk("s_vld", 256'(s_vld), 256'd1);
        chk("b_basic", b_dout, b_old);
        chk("b_vld", 256'(b_vld), 256'd1);
        s_ore = 1'b0; b_ore = 1'b0;
        s_we = 1'b1; s_di = 1'b0; s_re = 1'b1;
        b_we = 1'b1; b_di = b_new; b_re = 1'b1;
        tick();
        s_we = 1'b0; s_re = 1'b0; s_ore = 1'b1;
        b_we = 1'b0; b_re = 1'b0; b_ore = 1'b1;
        tick();
        chk("s_collide", 256'(s_dout), FWD ? 256'd0 : 256'd1);
        chk("b_collide", b_dout, FWD ? b_new : b_old);
        s_ore = 1'b0; s_re = 1'b1; b_ore = 1'b0; b_re = 1'b1;
        tick();
        s_re = 1'b0; s_ore = 1'b1; b_re = 1'b0; b_ore = 1'b1;
        tick();
        chk("s_after", 256'(s_dout), 256'd0);
        chk("b_after", b_dout, b_new);
        chk("s_err", 256'(s_err), 256'd0);
        chk("b_err", 256'(b_err), 256'd0);
        s_ore = 1'b0; b_ore = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nv_ram_rwsthp_gen.md
# nv_ram_rwsthp_gen

Parametrised two-port (one read, one write) RAM model with a registered read address stage, an output-enable register and a late bypass mux. It is the generic successor to the fixed-geometry rwsthp RAM models used across the NVDLA core buffers. Width and depth are generalised, and the array read is registered so FPGA block RAM can be inferred. It adds optional write-to-read forwarding, out-of-range address protection, an output-valid flag and reset of all control/output state.

## Interface
- WIDTH, 42, data width in bits (1..1024)
- DEPTH, 60, number of words (2..4096; need not be a power of 2)
- AW, 6, address width; must satisfy 2^AW >= DEPTH
- nvdla_core_clk  input  1  sole clock; all state updates on its rising edge
- nvdla_core_rstn  input  1  reset, asynchronous assert, active-low
- ra  input  AW  read address
- re  input  1  read enable, stage 1
- ore  input  1  output register enable, stage 2
- dout  output  WIDTH  registered read data
- dout_vld  output  1  dout holds data from a completed read or bypass
- wa  input  AW  write address
- we  input  1  write enable
- di  input  WIDTH  write data
- byp_sel  input  1  stage-2 select: load dbyp instead of array data
- dbyp  input  WIDTH  bypass data
- oob_err  output  1  sticky: an out-of-range read or write was attempted
- pwrbus_ram_pd  input  32  power-down bus; accepted, no functional effect

## Operation
- Write: if we && wa < DEPTH, M[wa] <= di at the edge. If we && wa >= DEPTH, the write is dropped and oob_err is set.
- Read stage 1: if re, then mem_q <= M[ra] (0 if ra >= DEPTH), oob_q <= (ra >= DEPTH), and rd_seen <= 1. If !re, mem_q, oob_q and rd_seen hold.
- Read stage 2: if ore, then dout <= byp_sel ? dbyp : (oob_q ? 0 : mem_q), and dout_vld <= byp_sel | rd_seen. If !ore, dout and dout_vld hold regardless of re, we or byp_sel.
- Out-of-range read with re: oob_err is set; the read returns all-zero data.
- oob_err stays set until reset.
- Reset (asynchronous, any time, including mid-read): mem_q, oob_q, rd_seen, dout, dout_vld and oob_err all go to 0. Array contents are not reset and are undefined after power-up. An in-flight read is discarded.
- Simultaneous we and re with different addresses: independent, no interaction.
- pwrbus_ram_pd is ignored functionally and must not be optimised into X.

## Timing
- Read latency is 2 edges. With re and ra=A in cycle N and ore in cycle N+1, dout shows the data in cycle N+2.
- A write in cycle N is visible to a read issued in cycle N+1 or later.
- Same-cycle write and read to the same address (we && re && wa==ra < DEPTH): behaviour is set by the macro in Configuration.
- byp_sel and dbyp are sampled only in the ore cycle. The bypass has 1-edge latency.
- Back-to-back reads (re every cycle, ore every cycle) sustain 1 word/cycle.
- No combinational path from any input to any output.

## Configuration
- NV_RAM_RWSTHP_WRFWD_EN defined:
  - A same-cycle, same-address write and read returns the new data: mem_q <= di.
  - This keeps the write-first semantics of the legacy models.
- Not defined:
  - The same case returns the old M[wa] contents (read-first).
  - The array read has no forwarding mux, which allows pure block-RAM inference.
- Out-of-range addresses never forward in either build.

## Test plan
- Reset and basic read:
  - Reset, then write M[5]=0x2A_0000_1234.
  - re with ra=5 in cycle N, ore in cycle N+1.
  - Required: dout=0x2A_0000_1234 and dout_vld=1 in cycle N+2. Before that, dout=0 and dout_vld=0.
- Same-cycle collision:
  - M[7]=0x111, then in one cycle we with wa=7, di=0x222 and re with ra=7; ore in the next cycle.
  - Required: dout=0x222 with NV_RAM_RWSTHP_WRFWD_EN, 0x111 without. A later re/ore on address 7 returns 0x222 in both builds.
- Bypass and hold:
  - After a read, stage 2 with ore=1, byp_sel=1, dbyp=0x3FF.
  - Required: dout=0x3FF and dout_vld=1.
  - Then ore=0 for 5 cycles while re/ra keep toggling: dout stays 0x3FF.
- Out-of-range (DEPTH=60, AW=6):
  - we with wa=62; then re with ra=61 and ore.
  - Required: dout=0, oob_err=1 from the first edge onward, and M[0..59] unchanged.
  - oob_err is still 1 after 100 idle cycles.
- Reset mid-read:
  - re with ra=3 in cycle N, nvdla_core_rstn low during cycle N+1.
  - Required: dout=0, dout_vld=0 and oob_err=0 immediately, with no stale data after release.
  - A new read of address 3 returns the previously written M[3].
- Parametrisation: repeat the basic read and collision tests with WIDTH=1/DEPTH=2/AW=1 and WIDTH=256/DEPTH=4096/AW=12, including reads of the highest valid address.
